// File: rtl/oam_dma_ctrl_pkg.sv
// Shared bus constants and DMA state encoding.
// Imported by the OAM DMA engine and the CPU bus decoder.
package oam_dma_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } dma_state_t;

    localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

endpackage

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA: a $4014 write stalls the CPU and copies page {data,$00..$FF} to OAMDATA.
// Transfer takes 513/514 cycles; it cannot be backpressured, only aborted by rst.
module oam_dma_ctrl
    import oam_dma_ctrl_pkg::*;
#(
    parameter int NUM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_cpu_addr,
    input  logic [7:0]  i_cpu_wdata,
    input  logic        i_cpu_write,
    input  logic [7:0]  i_mem_rdata,
    output logic        o_stall,
    output logic        o_dma_active,
    output logic [15:0] o_dma_addr,
    output logic        o_dma_read,
    output logic        o_dma_write,
    output logic [7:0]  o_dma_wdata,
    output logic        o_dma_done
);

    localparam int IDX_W = $clog2(NUM_BYTES);

    dma_state_t       r_state;
    dma_state_t       w_state_nxt;
    logic [7:0]       r_page;
    logic [IDX_W-1:0] r_idx;
    logic             r_parity;
    logic             r_done;
    logic             w_trigger;
    logic             w_last;

    assign w_trigger = i_cpu_write && (i_cpu_addr == DMA_REG_ADDR);
    assign w_last    = (r_idx == IDX_W'(NUM_BYTES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_page   <= 8'h00;
            r_idx    <= '0;
            r_parity <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_parity <= ~r_parity;
            r_done   <= (r_state == WRITE) && w_last;
            // Triggers while busy are dropped so the page cannot change mid-copy.
            if (r_state == IDLE && w_trigger) begin
                r_page <= i_cpu_wdata;
                r_idx  <= '0;
            end else if (r_state == WRITE) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        o_dma_addr   = 16'h0000;
        o_dma_read   = 1'b0;
        o_dma_write  = 1'b0;
        o_dma_wdata  = 8'h00;
        unique case (r_state)
            IDLE: begin
                if (w_trigger) w_state_nxt = HALT;
            end
            HALT: begin
                // Reads must fall on even cycles; insert ALIGN if the next one is odd.
                w_state_nxt = r_parity ? READ : ALIGN;
            end
            ALIGN: begin
                w_state_nxt = READ;
            end
            READ: begin
                o_dma_read  = 1'b1;
                o_dma_addr  = 16'({r_page, r_idx});
                w_state_nxt = WRITE;
            end
            WRITE: begin
                o_dma_write = 1'b1;
                o_dma_addr  = OAM_DATA_ADDR;
                o_dma_wdata = i_mem_rdata;
                w_state_nxt = w_last ? IDLE : READ;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign o_stall      = (r_state != IDLE);
    assign o_dma_active = (r_state != IDLE);
    assign o_dma_done   = r_done;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: cycle-offset transfer model plus directed scenarios.
module tb_oam_dma_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        cpu_write = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;
    logic        stall, dma_active, dma_read, dma_write, dma_done;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    oam_dma_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .i_cpu_addr   (cpu_addr),
        .i_cpu_wdata  (cpu_wdata),
        .i_cpu_write  (cpu_write),
        .i_mem_rdata  (mem_rdata),
        .o_stall      (stall),
        .o_dma_active (dma_active),
        .o_dma_addr   (dma_addr),
        .o_dma_read   (dma_read),
        .o_dma_write  (dma_write),
        .o_dma_wdata  (dma_wdata),
        .o_dma_done   (dma_done)
    );

    function automatic logic [7:0] memf(input logic [15:0] a);
        if (a == 16'hFFFF) return 8'hA5;
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
    endfunction

    // Memory with one-cycle registered read data.
    always @(posedge clk) if (dma_read) mem_rdata <= memf(dma_addr);

    // Model: a transfer is "pre" dummy cycles, then 256 read/write pairs.
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic       m_par  = 1'b0;
    int         m_k    = 0;
    int         m_pre  = 1;
    logic [7:0] m_page = 8'h00;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_par  <= 1'b0;
            m_k    <= 0;
        end else begin
            m_par  <= ~m_par;
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_k == m_pre + 511) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end else begin
                    m_k <= m_k + 1;
                end
            end else if (cpu_write && cpu_addr == 16'h4014) begin
                m_busy <= 1'b1;
                m_k    <= 0;
                m_page <= cpu_wdata;
                m_pre  <= m_par ? 2 : 1;
            end
        end
    end

    int          run_len = 0, last_len = 0, rd_in_xfer = 0;
    int          rd_total = 0, wr_total = 0, done_total = 0, zero_acc = 0, pg3_rd = 0;
    logic        first_rd_par = 1'b1;
    logic [15:0] last_rd_addr = 16'h0000;
    logic [7:0]  last_wdata = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_loop();
        int j, b;
        logic        e_rd, e_wr;
        logic [15:0] e_addr;
        logic [7:0]  e_wd;
        forever begin
            @(negedge clk);
            e_rd = 1'b0; e_wr = 1'b0; e_addr = 16'h0000; e_wd = 8'h00;
            if (m_busy && m_k >= m_pre) begin
                j = m_k - m_pre;
                b = j / 2;
                if (j % 2 == 0) begin
                    e_rd = 1'b1;
                    e_addr = {m_page, b[7:0]};
                end else begin
                    e_wr = 1'b1;
                    e_addr = 16'h2004;
                    e_wd = memf({m_page, b[7:0]});
                end
            end
            chk("bus{stall,act,rd,wr,done,addr,wdata}",
                {8'h0, stall, dma_active, dma_read, dma_write, dma_done, dma_addr, dma_wdata},
                {8'h0, m_busy, m_busy, e_rd, e_wr, m_done, e_addr, e_wd});
            if (stall) run_len++;
            else begin
                if (run_len != 0) last_len = run_len;
                run_len = 0;
                rd_in_xfer = 0;
            end
            if (dma_read) begin
                if (rd_in_xfer == 0) first_rd_par = m_par;
                rd_in_xfer++;
                rd_total++;
                last_rd_addr = dma_addr;
                if (dma_addr == 16'h0000) zero_acc++;
                if (dma_addr[15:8] == 8'h03) pg3_rd++;
            end
            if (dma_write) begin
                wr_total++;
                last_wdata = dma_wdata;
            end
            if (dma_done) done_total++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // halt_par is the parity the HALT cycle will see.
    task automatic trig(input logic [7:0] pg, input logic halt_par);
        tick();
        if (m_par == halt_par) tick();
        cpu_write = 1'b1; cpu_addr = 16'h4014; cpu_wdata = pg;
        tick();
        cpu_write = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (stall && n < 1000) begin
            tick();
            n++;
        end
        chk({name, "_ended"}, {31'h0, stall}, 32'h0);
    endtask

    int s_rd, s_wr, s_done, s_zero, s_pg3, n;

    initial begin
        repeat (2) @(posedge clk);
        fork
            compare_loop();
        join_none
        #2 rst = 1'b0;

        // 1: idle after reset
        s_rd = rd_total; s_wr = wr_total; s_done = done_total;
        repeat (100) tick();
        chk("t1_stall", {31'h0, stall}, 32'h0);
        chk("t1_accesses", rd_total + wr_total + done_total - s_rd - s_wr - s_done, 0);

        // 2: page $02, HALT on odd cycle, then back-to-back trigger of page $01 on the done cycle
        s_rd = rd_total; s_wr = wr_total; s_done = done_total;
        trig(8'h02, 1'b1);
        wait_idle("t2");
        chk("t2_done_pulse", {31'h0, dma_done}, 32'h1);
        cpu_write = 1'b1; cpu_addr = 16'h4014; cpu_wdata = 8'h01;
        tick();
        cpu_write = 1'b0; cpu_addr = 16'h0000;
        chk("t2_stall_len", last_len, 513);
        chk("t2_reads", rd_total - s_rd, 256);
        chk("t2_writes", wr_total - s_wr, 256);
        chk("t2_last_rd", last_rd_addr, 16'h02FF);
        chk("t2_last_wd", last_wdata, 8'hE3);
        chk("t2_done_cnt", done_total - s_done, 1);
        chk("b2b_restart", {31'h0, stall}, 32'h1);
        s_rd = rd_total;
        wait_idle("b2b");
        chk("b2b_reads", rd_total - s_rd, 256);
        chk("b2b_last_rd", last_rd_addr, 16'h01FF);

        // 3: HALT on even cycle needs ALIGN
        trig(8'h02, 1'b0);
        wait_idle("t3");
        tick();
        chk("t3_stall_len", last_len, 514);
        chk("t3_first_rd_even", {31'h0, first_rd_par}, 32'h0);

        // 4: page $FF does not wrap into page $00
        s_zero = zero_acc;
        trig(8'hFF, 1'b1);
        wait_idle("t4");
        tick();
        chk("t4_last_rd", last_rd_addr, 16'hFFFF);
        chk("t4_last_wd", last_wdata, 8'hA5);
        chk("t4_no_zero", zero_acc - s_zero, 0);

        // 5: retrigger while busy is ignored
        s_rd = rd_total; s_pg3 = pg3_rd;
        trig(8'h02, 1'b1);
        repeat (20) tick();
        cpu_write = 1'b1; cpu_addr = 16'h4014; cpu_wdata = 8'h03;
        tick();
        cpu_write = 1'b0; cpu_addr = 16'h0000;
        wait_idle("t5");
        tick();
        chk("t5_stall_len", last_len, 513);
        chk("t5_pg3", pg3_rd - s_pg3, 0);
        chk("t5_reads", rd_total - s_rd, 256);

        // Non-triggers: other address, read of $4014, trigger under reset
        cpu_write = 1'b1; cpu_addr = 16'h4015; cpu_wdata = 8'h07;
        tick();
        cpu_write = 1'b0; cpu_addr = 16'h4014;
        tick();
        cpu_addr = 16'h0000;
        tick();
        chk("nt_other_addr", {31'h0, stall}, 32'h0);
        rst = 1'b1; cpu_write = 1'b1; cpu_addr = 16'h4014; cpu_wdata = 8'h02;
        tick();
        rst = 1'b0; cpu_write = 1'b0; cpu_addr = 16'h0000;
        tick();
        chk("nt_rst_wins", {31'h0, stall}, 32'h0);

        // 6: reset at byte 100, then a fresh transfer of page $05
        trig(8'h02, 1'b1);
        n = 0;
        while (rd_in_xfer < 101 && n < 400) begin
            tick();
            n++;
        end
        chk("t6_reached_byte100", {31'h0, stall}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_outputs", {27'h0, stall, dma_active, dma_read, dma_write, dma_done}, 32'h0);
        s_rd = rd_total;
        trig(8'h05, 1'b1);
        wait_idle("t6");
        tick();
        chk("t6_stall_len", last_len, 513);
        chk("t6_reads", rd_total - s_rd, 256);
        chk("t6_last_rd", last_rd_addr, 16'h05FF);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
